// File: rtl/alu_issue_scheduler_if.sv
// rtl/alu_issue_scheduler_if.sv - scheduler handshake bundle: RS requests, ALU control, CDB writeback
interface alu_issue_scheduler_if #(
  parameter int N_ENTRIES = 16,
  parameter int IDX_W     = 4
);
  logic                 rdy;
  logic                 flush;
  logic [N_ENTRIES-1:0] req_ready;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;
  logic                 alu_start;
  logic                 alu_done;
  logic [31:0]          alu_result;
  logic                 wb_valid;
  logic [IDX_W-1:0]     wb_idx;
  logic [31:0]          wb_result;
  logic                 cdb_ack;
  logic [31:0]          issue_count;

  modport master (
    input  rdy, flush, req_ready, alu_done, alu_result, cdb_ack,
    output grant_valid, grant_idx, alu_start, wb_valid, wb_idx, wb_result, issue_count
  );

  modport slave (
    output rdy, flush, req_ready, alu_done, alu_result, cdb_ack,
    input  grant_valid, grant_idx, alu_start, wb_valid, wb_idx, wb_result, issue_count
  );
endinterface

// File: rtl/alu_issue_scheduler.sv
// rtl/alu_issue_scheduler.sv - round-robin issue of RS entries to the shared ALU with CDB hold and flush drain
module alu_issue_scheduler #(
  parameter int N_ENTRIES = 16,
  parameter int IDX_W     = 4
) (
  input logic                   clk,
  input logic                   rst,
  alu_issue_scheduler_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] sel;
  logic             any;
  logic             do_issue;

  // Scan starts at rr_ptr so the last-issued entry gets lowest priority.
  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             found;
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      idx = rr_ptr + IDX_W'(i);
      if (!found && bus.req_ready[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign any      = |bus.req_ready;
  assign do_issue = bus.rdy && !bus.flush && any &&
                    ((state == IDLE) || (state == HOLD && bus.cdb_ack));

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      cur_idx         <= '0;
      bus.grant_valid <= 1'b0;
      bus.grant_idx   <= '0;
      bus.alu_start   <= 1'b0;
      bus.wb_valid    <= 1'b0;
      bus.wb_idx      <= '0;
      bus.wb_result   <= '0;
      bus.issue_count <= '0;
    end else if (bus.rdy) begin
      bus.grant_valid <= 1'b0;
      bus.alu_start   <= 1'b0;
      if (bus.flush) begin
        bus.wb_valid <= 1'b0;
        case (state)
          IDLE: state <= IDLE;
          BUSY: begin
            bus.issue_count <= bus.issue_count - 32'd1;
            state           <= bus.alu_done ? IDLE : DRAIN;
          end
          HOLD: begin
            bus.issue_count <= bus.issue_count - 32'd1;
            state           <= IDLE;
          end
          DRAIN: state <= bus.alu_done ? IDLE : DRAIN;
          default: state <= IDLE;
        endcase
      end else begin
        case (state)
          IDLE: ;
          BUSY: begin
            if (bus.alu_done) begin
              bus.wb_valid  <= 1'b1;
              bus.wb_idx    <= cur_idx;
              bus.wb_result <= bus.alu_result;
              state         <= HOLD;
            end
          end
          HOLD: begin
            if (bus.cdb_ack) begin
              bus.wb_valid <= 1'b0;
              state        <= IDLE;
            end
          end
          DRAIN: begin
            if (bus.alu_done) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
        // Issue overrides the IDLE next-state chosen above, giving back-to-back ack+grant.
        if (do_issue) begin
          bus.grant_valid <= 1'b1;
          bus.alu_start   <= 1'b1;
          bus.grant_idx   <= sel;
          cur_idx         <= sel;
          rr_ptr          <= sel + IDX_W'(1);
          bus.issue_count <= bus.issue_count + 32'd1;
          state           <= BUSY;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// tb/tb_alu_issue_scheduler.sv - directed self-checking bench for alu_issue_scheduler
module tb_alu_issue_scheduler;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  alu_issue_scheduler_if #(.N_ENTRIES(16), .IDX_W(4)) bus ();

  alu_issue_scheduler #(.N_ENTRIES(16), .IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rr_exp [4];
    rr_exp = '{4'd0, 4'd15, 4'd0, 4'd15};
    tests_run        = 0;
    tests_failed     = 0;
    rst              = 1'b1;
    bus.rdy          = 1'b1;
    bus.flush        = 1'b0;
    bus.req_ready    = '0;
    bus.alu_done     = 1'b0;
    bus.alu_result   = '0;
    bus.cdb_ack      = 1'b0;
    tick();
    tick();
    check("rst_grant_valid", bus.grant_valid, 0);
    check("rst_alu_start", bus.alu_start, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_issue_count", bus.issue_count, 0);
    rst = 1'b0;

    // Single request, ALU latency 1
    bus.req_ready = 16'h0010;
    tick();
    check("single_grant_valid", bus.grant_valid, 1);
    check("single_grant_idx", bus.grant_idx, 4);
    check("single_alu_start", bus.alu_start, 1);
    bus.req_ready  = '0;
    bus.alu_done   = 1'b1;
    bus.alu_result = 32'h1234;
    tick();
    check("single_grant_pulse", bus.grant_valid, 0);
    check("single_wb_valid", bus.wb_valid, 1);
    check("single_wb_idx", bus.wb_idx, 4);
    check("single_wb_result", bus.wb_result, 32'h1234);
    bus.alu_done = 1'b0;
    bus.cdb_ack  = 1'b1;
    tick();
    check("single_wb_clear", bus.wb_valid, 0);
    check("single_issue_count", bus.issue_count, 1);

    // Round-robin wrap from a fresh pointer
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    bus.req_ready = 16'h8001;
    bus.cdb_ack   = 1'b1;
    tick();
    check("rr_grant0", bus.grant_idx, rr_exp[0]);
    for (int k = 1; k < 4; k++) begin
      bus.alu_done = 1'b1;
      tick();
      check("rr_wb_valid", bus.wb_valid, 1);
      bus.alu_done = 1'b0;
      tick();
      check("rr_regrant", bus.grant_valid, 1);
      check("rr_grant_idx", bus.grant_idx, rr_exp[k]);
    end
    bus.alu_done = 1'b1;
    tick();
    bus.req_ready = 16'h0006;
    bus.alu_done  = 1'b0;
    tick();
    check("rr_after15_idx", bus.grant_idx, 1);
    check("rr_count", bus.issue_count, 5);

    // CDB backpressure
    bus.alu_done   = 1'b1;
    bus.alu_result = 32'hCAFE;
    bus.cdb_ack    = 1'b0;
    tick();
    bus.alu_done  = 1'b0;
    bus.req_ready = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_wb_valid", bus.wb_valid, 1);
      check("bp_wb_idx", bus.wb_idx, 1);
      check("bp_wb_result", bus.wb_result, 32'hCAFE);
      check("bp_no_grant", bus.grant_valid, 0);
    end
    bus.cdb_ack = 1'b1;
    tick();
    check("bp_ack_wb_clear", bus.wb_valid, 0);
    check("bp_regrant", bus.grant_valid, 1);
    check("bp_regrant_idx", bus.grant_idx, 2);
    check("bp_count", bus.issue_count, 6);

    // Flush while entry 7 is in flight
    bus.alu_done = 1'b1;
    bus.cdb_ack  = 1'b0;
    tick();
    bus.alu_done  = 1'b0;
    bus.req_ready = 16'h0080;
    bus.cdb_ack   = 1'b1;
    tick();
    check("fl_grant7", bus.grant_idx, 7);
    check("fl_count_up", bus.issue_count, 7);
    bus.flush     = 1'b1;
    bus.req_ready = '0;
    tick();
    bus.flush = 1'b0;
    check("fl_count_back", bus.issue_count, 6);
    bus.req_ready = 16'h0001;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("fl_drain_no_grant", bus.grant_valid, 0);
      check("fl_drain_no_wb", bus.wb_valid, 0);
    end
    bus.alu_done = 1'b1;
    tick();
    check("fl_done_no_wb", bus.wb_valid, 0);
    check("fl_done_no_grant", bus.grant_valid, 0);
    check("fl_done_count", bus.issue_count, 6);
    bus.alu_done = 1'b0;
    tick();
    check("fl_next_grant", bus.grant_valid, 1);
    check("fl_next_idx", bus.grant_idx, 0);

    // Flush with alu_done in BUSY, then flush against an IDLE request
    bus.flush    = 1'b1;
    bus.alu_done = 1'b1;
    tick();
    check("fd_no_wb", bus.wb_valid, 0);
    check("fd_count", bus.issue_count, 6);
    bus.alu_done = 1'b0;
    tick();
    check("fi_no_grant", bus.grant_valid, 0);
    check("fi_count", bus.issue_count, 6);
    bus.flush = 1'b0;
    tick();
    check("fi_after_grant", bus.grant_valid, 1);
    check("fi_after_idx", bus.grant_idx, 0);

    // rdy low in HOLD freezes everything and ignores ack
    bus.alu_done   = 1'b1;
    bus.alu_result = 32'hBEEF;
    bus.cdb_ack    = 1'b0;
    tick();
    check("rdy_hold_wb", bus.wb_valid, 1);
    bus.rdy       = 1'b0;
    bus.cdb_ack   = 1'b1;
    bus.req_ready = 16'h0002;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rdy_frozen_wb", bus.wb_valid, 1);
      check("rdy_frozen_result", bus.wb_result, 32'hBEEF);
      check("rdy_frozen_grant", bus.grant_valid, 0);
      check("rdy_frozen_count", bus.issue_count, 7);
    end
    bus.alu_done = 1'b0;
    bus.rdy      = 1'b1;
    tick();
    check("rdy_ack_wb", bus.wb_valid, 0);
    check("rdy_ack_grant_idx", bus.grant_idx, 1);
    check("rdy_ack_count", bus.issue_count, 8);

    // Reset mid-BUSY
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstb_grant_valid", bus.grant_valid, 0);
    check("rstb_grant_idx", bus.grant_idx, 0);
    check("rstb_alu_start", bus.alu_start, 0);
    check("rstb_wb_valid", bus.wb_valid, 0);
    check("rstb_wb_result", bus.wb_result, 0);
    check("rstb_issue_count", bus.issue_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
